// File: rtl/reg_file.sv
// Register file with two combinational read ports carrying same-cycle write-through
// bypass, one registered debug read port, and a committed-write counter.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // An X on we makes commit X, and every `if (commit)` below takes its
  // false branch, so an undefined enable cannot corrupt state in simulation.
  assign commit = (we == 1'b1) && (waddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (!rst_n || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (commit && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (!rst_n || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (commit && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end

  // Debug port samples the stored (pre-write) value; it never sees the bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data <= '0;
    end else if (dbg_addr == '0) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else if (commit) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: inputs change on the falling edge, outputs are
// sampled before the next rising edge, expected data flows through exp_q.
module tb_reg_file;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_cnt;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_cnt(wr_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [15:0]       exp_cnt;
  logic [DATA_W-1:0] exp_v;
  int checks = 0;
  int errors = 0;

  // driver tasks
  task automatic drive_idle();
    we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; dbg_addr = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_cnt = '0;
  endtask

  task automatic model_commit();
    if (we && (waddr != '0)) begin
      ref_mem[waddr] = wdata;
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (a == '0) return '0;
    if (we && (waddr != '0) && (waddr == a)) return wdata;
    return ref_mem[a];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #3;
    // writes and bypass must be inert while reset is held
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D; raddr1 = 5'd4; raddr2 = 5'd4;
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL reset_bypass_rd1: got %h expected %h", rdata1, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rdata2 !== exp_v) begin errors++; $display("FAIL reset_bypass_rd2: got %h expected %h", rdata2, exp_v); end
    @(posedge clk); @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = a[ADDR_W-1:0];
      raddr2 = 5'(DEPTH - 1 - a);
      exp_q.push_back('0); exp_q.push_back('0);
      #1;
      checks++; exp_v = exp_q.pop_front();
      if (rdata1 !== exp_v) begin errors++; $display("FAIL reset_rd1[%0d]: got %h expected %h", a, rdata1, exp_v); end
      checks++; exp_v = exp_q.pop_front();
      if (rdata2 !== exp_v) begin errors++; $display("FAIL reset_rd2[%0d]: got %h expected %h", a, rdata2, exp_v); end
    end
    checks++;
    if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL reset_wr_cnt: got %h expected %h", wr_cnt, exp_cnt); end
    checks++;
    if (dbg_data !== '0) begin errors++; $display("FAIL reset_dbg: got %h expected 0", dbg_data); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd5;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    #2;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL bypass_rd1: got %h expected %h", rdata1, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rdata2 !== exp_v) begin errors++; $display("FAIL bypass_rd2: got %h expected %h", rdata2, exp_v); end
    model_commit();
    @(negedge clk);
    we = 1'b0;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    #2;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL stored_rd1: got %h expected %h", rdata1, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rdata2 !== exp_v) begin errors++; $display("FAIL stored_rd2: got %h expected %h", rdata2, exp_v); end
    checks++;
    if (wr_cnt !== 16'd1) begin errors++; $display("FAIL bypass_wr_cnt: got %h expected 0001", wr_cnt); end
  endtask

  task automatic test_zero_write();
    @(negedge clk);
    we = 1'b1; waddr = '0; wdata = 32'hFFFFFFFF; raddr1 = '0; raddr2 = '0;
    exp_q.push_back('0); exp_q.push_back('0);
    #2;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL zero_rd1_same: got %h expected %h", rdata1, exp_v); end
    checks++; exp_v = exp_q.pop_front();
    if (rdata2 !== exp_v) begin errors++; $display("FAIL zero_rd2_same: got %h expected %h", rdata2, exp_v); end
    model_commit();
    @(negedge clk);
    we = 1'b0;
    exp_q.push_back('0);
    #2;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL zero_rd1_next: got %h expected %h", rdata1, exp_v); end
    checks++;
    if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL zero_wr_cnt: got %h expected %h", wr_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cnt0;
    cnt0 = exp_cnt;
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h11111111; dbg_addr = 5'd7;
    exp_q.push_back(ref_mem[7]);           // pre-write value seen at edge 1
    model_commit();
    @(negedge clk);
    wdata = 32'h22222222;
    checks++; exp_v = exp_q.pop_front();
    if (dbg_data !== exp_v) begin errors++; $display("FAIL dbg_prewrite: got %h expected %h", dbg_data, exp_v); end
    exp_q.push_back(32'h11111111);
    model_commit();
    @(negedge clk);
    we = 1'b0;
    checks++; exp_v = exp_q.pop_front();
    if (dbg_data !== exp_v) begin errors++; $display("FAIL dbg_first: got %h expected %h", dbg_data, exp_v); end
    exp_q.push_back(32'h22222222);
    @(negedge clk);
    checks++; exp_v = exp_q.pop_front();
    if (dbg_data !== exp_v) begin errors++; $display("FAIL dbg_second: got %h expected %h", dbg_data, exp_v); end
    checks++;
    if (wr_cnt !== cnt0 + 16'd2) begin errors++; $display("FAIL b2b_wr_cnt: got %h expected %h", wr_cnt, cnt0 + 16'd2); end
    dbg_addr = '0;
    @(negedge clk);
    checks++;
    if (dbg_data !== '0) begin errors++; $display("FAIL dbg_addr0: got %h expected 0", dbg_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; exp_v = exp_q.pop_front();
        if (dbg_data !== exp_v) begin errors++; $display("FAIL rand_dbg[%0d]: got %h expected %h", i, dbg_data, exp_v); end
      end
      we       = ($urandom_range(0, 3) != 0);
      waddr    = ADDR_W'($urandom_range(0, DEPTH - 1));
      wdata    = $urandom;
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, DEPTH - 1));
      raddr2   = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, DEPTH - 1));
      dbg_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      exp_q.push_back(model_read(raddr1));
      exp_q.push_back(model_read(raddr2));
      #2;
      checks++; exp_v = exp_q.pop_front();
      if (rdata1 !== exp_v) begin errors++; $display("FAIL rand_rd1[%0d] a=%0d: got %h expected %h", i, raddr1, rdata1, exp_v); end
      checks++; exp_v = exp_q.pop_front();
      if (rdata2 !== exp_v) begin errors++; $display("FAIL rand_rd2[%0d] a=%0d: got %h expected %h", i, raddr2, rdata2, exp_v); end
      exp_q.push_back((dbg_addr == '0) ? '0 : ref_mem[dbg_addr]);
      model_commit();
    end
    @(negedge clk);
    we = 1'b0;
    checks++; exp_v = exp_q.pop_front();
    if (dbg_data !== exp_v) begin errors++; $display("FAIL rand_dbg_last: got %h expected %h", dbg_data, exp_v); end
    checks++;
    if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL rand_wr_cnt: got %h expected %h", wr_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5A5A5;
    model_commit();
    @(negedge clk);
    we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd31;
    exp_q.push_back(32'hA5A5A5A5);
    #2;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL areset_pre: got %h expected %h", rdata1, exp_v); end
    // assert reset mid-cycle, well before the next rising edge
    #1 rst_n = 1'b0;
    model_reset();
    exp_q.push_back('0);
    #1;
    checks++; exp_v = exp_q.pop_front();
    if (rdata1 !== exp_v) begin errors++; $display("FAIL areset_rd1: got %h expected %h", rdata1, exp_v); end
    checks++;
    if (wr_cnt !== 16'd0) begin errors++; $display("FAIL areset_wr_cnt: got %h expected 0000", wr_cnt); end
    // a write attempted during reset must be discarded
    we = 1'b1; waddr = 5'd9; wdata = 32'h0BADF00D;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0; raddr1 = 5'd9;
    #2;
    checks++;
    if (rdata1 !== '0) begin errors++; $display("FAIL reset_write_dropped: got %h expected 0", rdata1); end
    checks++;
    if (wr_cnt !== 16'd0) begin errors++; $display("FAIL reset_write_cnt: got %h expected 0000", wr_cnt); end
    // first rising edge after release accepts a write
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h12345678;
    model_commit();
    @(negedge clk);
    we = 1'b0;
    #2;
    checks++;
    if (rdata1 !== ref_mem[9]) begin errors++; $display("FAIL first_write: got %h expected %h", rdata1, ref_mem[9]); end
    checks++;
    if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL first_write_cnt: got %h expected %h", wr_cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      wdata = $urandom;
      model_commit();
      @(negedge clk);
      if (i == 65534) begin
        checks++;
        if (wr_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffff", wr_cnt); end
      end
    end
    we = 1'b0; raddr1 = 5'd1;
    #2;
    checks++;
    if (wr_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_zero: got %h expected %h", wr_cnt, exp_cnt); end
    checks++;
    if (rdata1 !== ref_mem[1]) begin errors++; $display("FAIL wrap_last_data: got %h expected %h", rdata1, ref_mem[1]); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_write();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W (32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 we  input  1  write enable for the destination register.
REQ-006 waddr  input  ADDR_W  destination register number (output of the rd/rt destination select).
REQ-007 wdata  input  DATA_W  write-back data.
REQ-008 raddr1  input  ADDR_W  read port 1 address (rs).
REQ-009 rdata1  output  DATA_W  read port 1 data.
REQ-010 raddr2  input  ADDR_W  read port 2 address (rt).
REQ-011 rdata2  output  DATA_W  read port 2 data.
REQ-012 dbg_addr  input  ADDR_W  debug read address.
REQ-013 dbg_data  output  DATA_W  debug read data, registered.
REQ-014 wr_cnt  output  16  count of committed writes since reset.

Function
REQ-015 Storage: 2**ADDR_W registers of DATA_W bits; register 0 reads as 0 at all times.
REQ-016 Write: on rising clk with we=1 and waddr!=0, reg[waddr] <= wdata; value visible to the following cycle's reads.
REQ-017 Write with waddr=0: discarded, reg 0 unchanged, wr_cnt not incremented.
REQ-018 Read ports 1/2: combinational, zero-latency, independent; rdataN = reg[raddrN].
REQ-019 Bypass: if we=1, waddr!=0 and raddrN==waddr in the same cycle, rdataN = wdata (write-through); applies to each port independently, including both ports on the same address.
REQ-020 raddrN=0: rdataN = 0 regardless of we/waddr/wdata.
REQ-021 Debug port: dbg_data <= reg[dbg_addr] each rising edge (1-cycle latency, pre-write value; no bypass); dbg_addr=0 yields 0.
REQ-022 wr_cnt: increments by 1 on each committed write (REQ-016); wraps 0xFFFF -> 0x0000; no saturation.
REQ-023 Consecutive writes to the same address: last write wins; each counted.
REQ-024 X/undefined we shall not corrupt registers in simulation: only we==1 writes.

Reset
REQ-025 rst_n=0 asynchronously clears all registers to 0, dbg_data to 0, wr_cnt to 0, without waiting for clk.
REQ-026 While rst_n=0, writes are ignored; rdata1/rdata2 return 0 for every address, bypass disabled.
REQ-027 Reset asserted in the same cycle as a write: write discarded, wr_cnt stays 0.
REQ-028 First write accepted on the first rising edge with rst_n=1 sampled high.

Verification
REQ-029 Reset then read all 32 addresses on both ports -> every rdata = 0x00000000, wr_cnt = 0.
REQ-030 we=1,waddr=5,wdata=0xDEADBEEF, raddr1=raddr2=5 same cycle -> rdata1=rdata2=0xDEADBEEF (bypass); next cycle we=0 -> still 0xDEADBEEF; wr_cnt=1.
REQ-031 we=1,waddr=0,wdata=0xFFFFFFFF; raddr1=0 -> rdata1=0 in that and next cycle; wr_cnt unchanged.
REQ-032 Write 0x11111111 then 0x22222222 to reg 7 on back-to-back edges; dbg_addr=7 -> dbg_data=0x11111111 one cycle after first edge, 0x22222222 after second; wr_cnt +2.
REQ-033 65536 writes to reg 1 -> wr_cnt returns to 0x0000; reg 1 holds last data.
REQ-034 Write 0xA5A5A5A5 to reg 31, assert rst_n=0 mid-cycle -> rdata1(raddr1=31)=0 immediately, wr_cnt=0, before any clk edge.
